qam_symbol_modulator: RTL
=========================

Name: qam_symbol_modulator

Overview:
- Parametrised successor to the fixed 16-QAM modulation path.
- Buffers incoming symbols in a FIFO and paces them out at a programmable symbol rate.
- Maps each symbol onto a runtime-selectable QPSK/16-QAM/64-QAM Gray-coded constellation, then mixes it with the NCO carrier: out = I_level*ipI - Q_level*ipQ.
- Sits between the Streamer (symbol source) and the PWM output stage; mode and period come from the register file.

Parameters:
- MAX_BITS, 6, width of ipSymbol; maximum bits per symbol (64-QAM).
- DEPTH, 16, symbol FIFO depth; power of two, at least 2.
- CARRIER_W, 18, signed width of NCO inputs ipI/ipQ.
- AMP_W, 8, signed width of constellation levels.
- (localparam) OUT_W = CARRIER_W+AMP_W+1; LVL_W = $clog2(DEPTH)+1.

Ports:
- ipClk  in  1  system clock; single clock domain.
- ipReset  in  1  synchronous, active-high reset.
- ipEnable  in  1  run symbol timer and output pipeline.
- ipMode  in  2  0=QPSK(k=1), 1=16-QAM(k=2), 2=64-QAM(k=3), 3=treated as QPSK.
- ipSymbolPeriod  in  16  clocks per symbol; values 0 and 1 are clamped to 2.
- ipSymbol  in  MAX_BITS  symbol data; bits [2k-1:k] = I index, [k-1:0] = Q index; bits above 2k ignored.
- ipSymbolValid  in  1  symbol write request.
- opSymbolReady  out  1  FIFO can accept a symbol.
- ipI, ipQ  in  CARRIER_W  signed NCO cosine/sine.
- ipClearStatus  in  1  clears opUnderflow.
- opModulated  out  OUT_W  signed modulated sample.
- opModulatedValid  out  1  opModulated is meaningful.
- opFifoLevel  out  LVL_W  current FIFO occupancy.
- opUnderflow  out  1  sticky: a symbol tick found the FIFO empty.

Behaviour:
- Reset (synchronous, active-high): FIFO emptied; symbol counter=0; I/Q levels=0; product and output registers=0.
  - Held low/zero: opModulatedValid, opModulated, opFifoLevel, opUnderflow.
  - opSymbolReady is 0 while ipReset is high and 1 from the first cycle after reset.
- Reset mid-operation discards FIFO contents and the symbol in flight; there is no partial output.
- FIFO:
  - Write when ipSymbolValid && opSymbolReady; opSymbolReady = (level != DEPTH).
  - A write while full is ignored.
  - Pop occurs only on a symbol tick with level != 0. A write and a pop in the same cycle leave the level unchanged.
  - No bypass: a symbol written into an empty FIFO is poppable from the next cycle.
  - Read/write pointers wrap modulo DEPTH.
- Symbol timer:
  - While ipEnable=1, the counter decrements each cycle. Tick when counter==0; on a tick, reload with max(ipSymbolPeriod,2)-1.
  - After reset, the first tick occurs on the first enabled cycle.
  - While ipEnable=0: counter frozen, no ticks, levels held.
- Tick handling:
  - ipMode is sampled only on a tick, so a mode change never alters the symbol currently held.
  - On a tick with a non-empty FIFO, pop the symbol and load the level registers (visible next cycle).
  - On a tick with an empty FIFO, load levels=0 and set opUnderflow.
  - If ipClearStatus and a set event occur in the same cycle, set wins.
- Mapping, per axis:
  - Gray-decode the k-bit index g to binary b.
  - level = (2b-(2^k-1))*S, where S = floor(3*2^(AMP_W-3)/(2^k-1)). For AMP_W=8, S = 96/32/13 for QPSK/16-QAM/64-QAM, so |level| <= 96.
- Datapath (all registers):
  - Stage A: PI = Ilevel*ipI, PQ = Qlevel*ipQ, each signed, CARRIER_W+AMP_W bits.
  - Stage B: opModulated = PI-PQ, sign-extended to OUT_W; no saturation is needed.
- Latency:
  - ipI/ipQ at cycle n appear in opModulated at n+2.
  - A tick at cycle t gives new levels at t+1 and the first output using them at t+3.
- opModulatedValid = ipEnable delayed by 2 cycles. On ipEnable fall, the pipeline drains 2 more valid samples, then valid=0 and opModulated holds its last value.
- opFifoLevel is registered and updates in the cycle after the write/pop.

Test Plan:
- QPSK: mode 0, period 4, ipI=1000, ipQ=0, push 2'b10 then 2'b00 -> opModulated = +96000 for 4 cycles, then -96000 for 4; valid high throughout.
- 16-QAM: mode 1, ipI=ipQ=100, push 4'b1000 then 4'b0111 -> +19200 (levels +96/-96), then -6400 (levels -32/+32).
- 64-QAM extreme: mode 2, ipI=ipQ=-131072, symbol 6'b100000 (levels +91/-91) -> -23855104; no overflow in the 27-bit output.
- FIFO full: ipEnable=0, push 20 back-to-back -> 16 accepted, opSymbolReady=0 after the 16th, opFifoLevel=16. Enable with period 2 -> level decrements every 2 cycles; ready rises after the first pop.
- Underflow: enable with an empty FIFO -> opModulated=0, opUnderflow=1. ipClearStatus coinciding with the next empty tick -> flag stays 1. Clear on a non-tick cycle -> 0.
- Reset mid-stream: assert ipReset with 5 symbols queued -> next cycle opFifoLevel=0, opModulatedValid=0, opModulated=0; opSymbolReady=1 on the first cycle after release.

Source files
------------

// File: rtl/qam_symbol_modulator.sv
// QAM symbol modulator: symbol FIFO, symbol-rate timer,
// Gray-coded QPSK/16/64-QAM mapper and carrier mixer.
module qam_symbol_modulator #(
  parameter int MAX_BITS  = 6,
  parameter int DEPTH     = 16,
  parameter int CARRIER_W = 18,
  parameter int AMP_W     = 8,
  localparam int OUT_W    = CARRIER_W + AMP_W + 1,
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                        ipClk,
  input  logic                        ipReset,
  input  logic                        ipEnable,
  input  logic [1:0]                  ipMode,
  input  logic [15:0]                 ipSymbolPeriod,
  input  logic [MAX_BITS-1:0]         ipSymbol,
  input  logic                        ipSymbolValid,
  output logic                        opSymbolReady,
  input  logic signed [CARRIER_W-1:0] ipI,
  input  logic signed [CARRIER_W-1:0] ipQ,
  input  logic                        ipClearStatus,
  output logic signed [OUT_W-1:0]     opModulated,
  output logic                        opModulatedValid,
  output logic [LVL_W-1:0]            opFifoLevel,
  output logic                        opUnderflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int PROD_W = CARRIER_W + AMP_W;
  localparam int S_FULL = 3 * (2 ** (AMP_W - 3));
  localparam logic [AMP_W-1:0] S1 = AMP_W'(S_FULL / 1);
  localparam logic [AMP_W-1:0] S2 = AMP_W'(S_FULL / 3);
  localparam logic [AMP_W-1:0] S3 = AMP_W'(S_FULL / 7);

  logic [MAX_BITS-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [LVL_W-1:0]         level;
  logic [15:0]              cnt, period_m1;
  logic                     tick, push, pop;
  logic [5:0]               head;
  logic [2:0]               gi, gq;
  logic [3:0]               nmax;
  logic [AMP_W-1:0]         scale;
  logic signed [AMP_W-1:0]  map_i, map_q;
  logic signed [AMP_W-1:0]  lvl_i, lvl_q;
  logic signed [PROD_W-1:0] prod_i, prod_q;
  logic                     en_d1;

  // Axis index (Gray) to signed amplitude: (2b - (2^k-1)) * S
  function automatic logic signed [AMP_W-1:0] amp(
    input logic [2:0]       g,
    input logic [3:0]       nm,
    input logic [AMP_W-1:0] sc
  );
    logic [2:0]              b;
    logic signed [4:0]       d;
    logic signed [AMP_W+5:0] p;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = g[2] ^ g[1] ^ g[0];
    d = $signed({1'b0, b, 1'b0}) - $signed({1'b0, nm});
    p = (AMP_W+6)'(d) * (AMP_W+6)'($signed({1'b0, sc}));
    return p[AMP_W-1:0];
  endfunction

  assign opSymbolReady = !ipReset && (level != LVL_W'(DEPTH));
  assign push      = ipSymbolValid && opSymbolReady;
  assign tick      = ipEnable && (cnt == 16'd0);
  assign pop       = tick && (level != '0);
  assign period_m1 = (ipSymbolPeriod < 16'd2) ? 16'd1
                   : ipSymbolPeriod - 16'd1;
  assign head        = 6'(mem[rd_ptr]);
  assign opFifoLevel = level;

  // Split the head symbol into I/Q indices for the mode in force now
  always_comb begin
    gi    = '0;
    gq    = '0;
    nmax  = 4'd1;
    scale = S1;
    unique case (ipMode)
      2'd1: begin
        gi    = {1'b0, head[3:2]};
        gq    = {1'b0, head[1:0]};
        nmax  = 4'd3;
        scale = S2;
      end
      2'd2: begin
        gi    = head[5:3];
        gq    = head[2:0];
        nmax  = 4'd7;
        scale = S3;
      end
      default: begin
        gi    = {2'b00, head[1]};
        gq    = {2'b00, head[0]};
        nmax  = 4'd1;
        scale = S1;
      end
    endcase
    map_i = amp(gi, nmax, scale);
    map_q = amp(gq, nmax, scale);
  end

  // Symbol storage; contents need no reset, occupancy guards reads
  always_ff @(posedge ipClk) begin
    if (push)
      mem[wr_ptr] <= ipSymbol;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Symbol-rate down-counter; ticks at zero and reloads
  always_ff @(posedge ipClk) begin
    if (ipReset)
      cnt <= '0;
    else if (tick)
      cnt <= period_m1;
    else if (ipEnable)
      cnt <= cnt - 16'd1;
  end

  // Level registers and sticky underflow, updated on ticks
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      lvl_i       <= '0;
      lvl_q       <= '0;
      opUnderflow <= 1'b0;
    end else begin
      if (tick) begin
        lvl_i <= pop ? map_i : '0;
        lvl_q <= pop ? map_q : '0;
      end
      if (tick && !pop)
        opUnderflow <= 1'b1;
      else if (ipClearStatus)
        opUnderflow <= 1'b0;
    end
  end

  // Two-stage mixer: products, then difference
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      prod_i           <= '0;
      prod_q           <= '0;
      en_d1            <= 1'b0;
      opModulated      <= '0;
      opModulatedValid <= 1'b0;
    end else begin
      en_d1            <= ipEnable;
      opModulatedValid <= en_d1;
      if (ipEnable) begin
        prod_i <= PROD_W'(lvl_i) * PROD_W'(ipI);
        prod_q <= PROD_W'(lvl_q) * PROD_W'(ipQ);
      end
      if (en_d1)
        opModulated <= OUT_W'(prod_i) - OUT_W'(prod_q);
    end
  end

endmodule
